// File: rtl/cgra_mport_arbiter_if.sv
// cgra_mport_arbiter_if
// Bundles the CGRA-side TCDM requester ports and the shared OBI-style bus
// master port of the memory-port arbiter.
//
// Handshake: a requester holds port_req_i (with we/be/addr/wdata) stable until
// it sees port_gnt_o in the same cycle; that cycle is the transfer. On the bus
// side a transfer happens in the cycle where bus_req_o && bus_gnt_i. Every
// transfer (read or write) is answered later by exactly one bus_rvalid_i
// pulse, in order; port_rvalid_o routes it to the issuing port and
// port_rdata_o carries the data.
//
// Modports:
//   slave  - the arbiter's view (consumes requests, drives the bus)
//   master - the environment's view (CGRA requesters plus the system bus)
interface cgra_mport_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [N_PORTS-1:0]        port_req_i;
  logic [N_PORTS-1:0]        port_gnt_o;
  logic [N_PORTS-1:0]        port_rvalid_o;
  logic [N_PORTS-1:0]        port_we_i;
  logic [N_PORTS*4-1:0]      port_be_i;
  logic [N_PORTS*ADDR_W-1:0] port_addr_i;
  logic [N_PORTS*DATA_W-1:0] port_wdata_i;
  logic [DATA_W-1:0]         port_rdata_o;

  logic                      bus_req_o;
  logic                      bus_gnt_i;
  logic                      bus_rvalid_i;
  logic                      bus_we_o;
  logic [3:0]                bus_be_o;
  logic [ADDR_W-1:0]         bus_addr_o;
  logic [DATA_W-1:0]         bus_wdata_o;
  logic [DATA_W-1:0]         bus_rdata_i;

  modport slave (
    input  port_req_i, port_we_i, port_be_i, port_addr_i, port_wdata_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output port_gnt_o, port_rvalid_o, port_rdata_o,
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );

  modport master (
    output port_req_i, port_we_i, port_be_i, port_addr_i, port_wdata_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  port_gnt_o, port_rvalid_o, port_rdata_o,
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/cgra_mport_arbiter.sv
// cgra_mport_arbiter
// Round-robin arbiter sharing one OBI-style bus master port among N_PORTS
// CGRA TCDM requesters. The selection is locked while a request waits for
// grant, and an in-order ID FIFO routes each rvalid back to its issuer.
//
// Ports:
//   clk_i, rstn_i     clock, asynchronous active-low reset
//   mp                arbiter_if.slave: requester ports + shared bus port
//   err_o             sticky: rvalid arrived with nothing outstanding
//   dbg_rr_ptr_o      round-robin search start
//   dbg_lock_valid_o  selection currently held for a stalled request
//   dbg_fifo_cnt_o    number of transfers awaiting rvalid
module cgra_mport_arbiter #(
  parameter int N_PORTS         = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  cgra_mport_arbiter_if.slave                   mp,
  output logic                                  err_o,
  output logic [$clog2(N_PORTS)-1:0]            dbg_rr_ptr_o,
  output logic                                  dbg_lock_valid_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  dbg_fifo_cnt_o
);
  localparam int IDX_W = $clog2(N_PORTS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] fifo_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] rr_idx;
  logic             rr_hit;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] head_idx;
  logic             fifo_full;
  logic             accept;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_ptr_q, wrapping modulo N_PORTS.
  always_comb begin
    rr_idx = rr_ptr_q;
    rr_hit = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_PORTS)) cand = cand - (IDX_W+1)'(N_PORTS);
      if (!rr_hit && mp.port_req_i[cand[IDX_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = cand[IDX_W-1:0];
      end
    end
  end

  // A stalled request keeps its slot so the bus sees stable req/addr.
  assign sel_idx   = lock_valid_q ? lock_idx_q : rr_idx;
  assign fifo_full = (cnt_q == FULL_CNT);
  assign head_idx  = fifo_mem_q[rd_ptr_q];

  assign mp.bus_req_o   = (|mp.port_req_i) && !fifo_full;
  assign mp.bus_we_o    = mp.port_we_i[sel_idx];
  assign mp.bus_be_o    = mp.port_be_i[int'(sel_idx)*4 +: 4];
  assign mp.bus_addr_o  = mp.port_addr_i[int'(sel_idx)*ADDR_W +: ADDR_W];
  assign mp.bus_wdata_o = mp.port_wdata_i[int'(sel_idx)*DATA_W +: DATA_W];

  assign accept = mp.bus_req_o && mp.bus_gnt_i;
  assign pop    = mp.bus_rvalid_i && (cnt_q != '0);

  assign mp.port_gnt_o    = accept ? (N_PORTS'(1) << sel_idx) : '0;
  assign mp.port_rvalid_o = pop ? (N_PORTS'(1) << head_idx) : '0;
  assign mp.port_rdata_o  = mp.bus_rdata_i;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;

    if (accept) begin
      lock_valid_d = 1'b0;
      rr_ptr_d     = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
      wr_ptr_d     = ptr_inc(wr_ptr_q);
    end else if (mp.bus_req_o) begin
      lock_valid_d = 1'b1;
      lock_idx_d   = sel_idx;
    end

    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (mp.bus_rvalid_i && (cnt_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      if (accept) fifo_mem_q[wr_ptr_q] <= sel_idx;
    end
  end

  assign err_o            = err_q;
  assign dbg_rr_ptr_o     = rr_ptr_q;
  assign dbg_lock_valid_o = lock_valid_q;
  assign dbg_fifo_cnt_o   = cnt_q;
endmodule
